// File: rtl/disp_pkg.sv
//------------------------------------------------------------------------------
// Module   : disp_pkg
// Purpose  : Shared types and widths for the display scheduler.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package disp_pkg;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 11;
    localparam int CNT_W  = 32;
    localparam int IDX_W  = $clog2(N_REQ);

    // Reset value of last_grant: the top index, so requester 0 is searched first.
    localparam logic [IDX_W-1:0] LAST_GRANT_RST = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/disp_sched_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick, searching upward from last_grant+1.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
    import disp_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    int idx;

    // Walk from the farthest candidate to the nearest; the last hit written wins,
    // which is the first requester found going upward from last_grant+1.
    always_comb begin
        grant_idx   = last_grant;
        grant_valid = 1'b0;
        idx         = 0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = (int'(last_grant) + i) % N_REQ;
            if (req[IDX_W'(idx)]) begin
                grant_idx   = IDX_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/disp_sched.sv
//------------------------------------------------------------------------------
// Module   : disp_sched
// Purpose  : Round-robin scheduler sharing one 7-segment display datapath.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module disp_sched
    import disp_pkg::*;
#(
    parameter int          N_REQ       = disp_pkg::N_REQ,
    parameter int unsigned HOLD_CYCLES = 50_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic                      disp_sel,
    output logic [DATA_W-1:0]         disp_data,
    output logic [IDX_W-1:0]          owner,
    output logic                      busy
);

    state_t             state_q,      state_d;
    logic [DATA_W-1:0]  disp_data_q,  disp_data_d;
    logic [IDX_W-1:0]   owner_q,      owner_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic               disp_sel_q,   disp_sel_d;
    logic [N_REQ-1:0]   ack_q,        ack_d;

    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;

    rr_arbiter u_arb (
        .req         (req),
        .last_grant  (last_grant_q),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            disp_data_q  <= '0;
            owner_q      <= '0;
            last_grant_q <= LAST_GRANT_RST;
            cnt_q        <= '0;
            disp_sel_q   <= 1'b0;
            ack_q        <= '0;
        end else begin
            state_q      <= state_d;
            disp_data_q  <= disp_data_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            disp_sel_q   <= disp_sel_d;
            ack_q        <= ack_d;
        end
    end

    // Strobes default low every cycle; only the LOAD state raises them.
    always_comb begin
        state_d      = state_q;
        disp_data_d  = disp_data_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        disp_sel_d   = 1'b0;
        ack_d        = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    disp_data_d  = req_data[grant_idx*DATA_W +: DATA_W];
                    owner_d      = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                disp_sel_d     = 1'b1;
                ack_d[owner_q] = 1'b1;
                cnt_d          = CNT_W'(HOLD_CYCLES - 1);
                state_d        = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ack       = ack_q;
    assign disp_sel  = disp_sel_q;
    assign disp_data = disp_data_q;
    assign owner     = owner_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_disp_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_disp_sched
// Purpose  : Directed self-checking bench for disp_sched with a grant scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_disp_sched;

    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [43:0] req_data;
    logic [3:0]  ack;
    logic        disp_sel;
    logic [10:0] disp_data;
    logic [1:0]  owner;
    logic        busy;

    typedef struct {
        logic [3:0]  ack;
        logic [10:0] data;
        logic [1:0]  owner;
        int          gap;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_sel_cyc = 0;
    int   busy_run = 0;
    int   last_busy_run = 0;

    disp_sched #(.N_REQ(4), .HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .disp_sel  (disp_sel),
        .disp_data (disp_data),
        .owner     (owner),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] who, input logic [10:0] data, input int gap);
        exp_t e;
        e.ack   = 4'b0001 << who;
        e.data  = data;
        e.owner = who;
        e.gap   = gap;
        sb.push_back(e);
    endtask

    task automatic set_slice(input int k, input logic [10:0] v);
        req_data[k*11 +: 11] = v;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, sb.size(), 0);
        sb.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // Monitor: every load strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (disp_sel === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_grant", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("grant_ack", ack, e.ack);
                    check("grant_data", disp_data, e.data);
                    check("grant_owner", owner, e.owner);
                    if (e.gap > 0) check("grant_spacing", cyc - last_sel_cyc, e.gap);
                end
                last_sel_cyc = cyc;
            end else begin
                check("ack_without_sel", ack, 0);
            end
            if (busy === 1'b1) begin
                busy_run++;
            end else if (busy_run != 0) begin
                last_busy_run = busy_run;
                busy_run = 0;
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        req      = 4'b0000;
        req_data = '0;
        tick(2);
        check("rst_disp_sel", disp_sel, 0);
        check("rst_ack", ack, 0);
        check("rst_disp_data", disp_data, 0);
        check("rst_owner", owner, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(3);
        check("idle_no_req_busy", busy, 0);

        // Single requester 2: latency, data and busy length.
        set_slice(2, 11'h005);
        req = 4'b0100;
        push(2'd2, 11'h005, 0);
        @(negedge clk);
        @(negedge clk);
        check("latency_sel_early", disp_sel, 0);
        check("latency_busy_load", busy, 1);
        @(negedge clk);
        check("latency_sel_on_time", disp_sel, 1);
        #1;
        req = 4'b0000;
        wait_drain("t1_drain", 5);
        wait_idle("t1_idle", 20);
        tick(2);
        check("t1_busy_len", last_busy_run, HOLD + 1);
        check("t1_data_stable", disp_data, 11'h005);
        check("t1_owner_stable", owner, 2);

        // All four requesting: rotation 0,1,2,3,0 every HOLD+2 cycles.
        do_reset();
        for (int k = 0; k < 4; k++) set_slice(k, 11'h100 + 11'(k));
        req = 4'b1111;
        push(2'd0, 11'h100, 0);
        push(2'd1, 11'h101, HOLD + 2);
        push(2'd2, 11'h102, HOLD + 2);
        push(2'd3, 11'h103, HOLD + 2);
        push(2'd0, 11'h100, HOLD + 2);
        wait_drain("t2_drain", 80);
        req = 4'b0000;
        wait_idle("t2_idle", 20);

        // Requesters 0 and 2 alternate; 1 and 3 are never chosen.
        set_slice(0, 11'h3FF);
        set_slice(2, 11'h400);
        req = 4'b0101;
        push(2'd2, 11'h400, 0);
        push(2'd0, 11'h3FF, HOLD + 2);
        push(2'd2, 11'h400, HOLD + 2);
        push(2'd0, 11'h3FF, HOLD + 2);
        wait_drain("t3_drain", 60);
        req = 4'b0000;
        wait_idle("t3_idle", 20);

        // Negative value passes bit-exact.
        set_slice(1, 11'h7FB);
        req = 4'b0010;
        push(2'd1, 11'h7FB, 0);
        wait_drain("t4_drain", 20);
        req = 4'b0000;
        wait_idle("t4_idle", 20);

        // A request raised during HOLD stays pending and leaves disp_data alone.
        set_slice(0, 11'h2AA);
        req = 4'b0001;
        push(2'd0, 11'h2AA, 0);
        wait_drain("t5_drain", 20);
        set_slice(3, 11'h155);
        req = 4'b1000;
        push(2'd3, 11'h155, HOLD + 2);
        tick(3);
        check("t5_hold_data", disp_data, 11'h2AA);
        check("t5_hold_owner", owner, 0);
        wait_drain("t5_drain2", 30);
        req = 4'b0000;
        wait_idle("t5_idle", 20);

        // One-cycle request: captured data survives the request dropping.
        set_slice(3, 11'h0F0);
        req = 4'b1000;
        push(2'd3, 11'h0F0, 0);
        tick(1);
        req = 4'b0000;
        set_slice(3, 11'h000);
        wait_drain("t6_drain", 20);
        wait_idle("t6_idle", 20);

        // Reset in HOLD cycle 4 aborts; restart grants requester 1 first.
        set_slice(0, 11'h011);
        req = 4'b0001;
        push(2'd0, 11'h011, 0);
        wait_drain("t7_drain", 20);
        req = 4'b0000;
        tick(2);
        rst_n = 1'b0;
        #1;
        check("t7_rst_sel", disp_sel, 0);
        check("t7_rst_ack", ack, 0);
        check("t7_rst_data", disp_data, 0);
        check("t7_rst_owner", owner, 0);
        check("t7_rst_busy", busy, 0);
        tick(2);
        set_slice(1, 11'h033);
        set_slice(3, 11'h077);
        req = 4'b1010;
        push(2'd1, 11'h033, 0);
        rst_n = 1'b1;
        wait_drain("t7_drain2", 20);
        req = 4'b0000;
        wait_idle("t7_idle", 20);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/disp_sched.md
DISP_SCHED -- requirements
Module: disp_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the 7-segment display datapath (fixed at 4 in this revision).
REQ-002 Parameter HOLD_CYCLES, default 50_000_000: minimum cycles a granted value owns the display before re-arbitration; legal range 1 to 2^32-1.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  4  per-requester request level; held high until the matching ack.
REQ-006 req_data  input  44  four packed 11-bit two's-complement values; requester k at bits [11k+10:11k].
REQ-007 ack  output  4  one-hot, one-cycle pulse when requester k's value is loaded.
REQ-008 disp_sel  output  1  one-cycle load strobe to the display driver's sel input.
REQ-009 disp_data  output  11  value driven to the display driver's data_in.
REQ-010 owner  output  2  index of the most recently granted requester.
REQ-011 busy  output  1  high in LOAD and HOLD states.

Function
REQ-012 The FSM SHALL have three states: IDLE, LOAD, HOLD.
REQ-013 In IDLE, with any req bit high, the block SHALL pick a winner round-robin, searching from last_grant+1 modulo 4 upward, capture its 11-bit slice into disp_data, update owner/last_grant, and enter LOAD on that edge.
REQ-014 In IDLE with req == 0, the block SHALL stay in IDLE with all outputs unchanged except strobes, which are low.
REQ-015 In LOAD, the block SHALL assert disp_sel and ack[owner] for exactly one cycle, load the hold counter with HOLD_CYCLES-1, and enter HOLD.
REQ-016 Latency: req sampled high in IDLE at edge t SHALL give disp_sel/ack high during the cycle after edge t+1 (one registered cycle).
REQ-017 In HOLD, the counter SHALL decrement each cycle; at count 0 the FSM SHALL return to IDLE; with HOLD_CYCLES=1 HOLD SHALL last exactly one cycle.
REQ-018 A requester dropping req after capture SHALL NOT cancel the transaction; LOAD and ack SHALL still occur with the captured data.
REQ-019 Requests arriving during LOAD or HOLD SHALL remain pending and SHALL NOT affect disp_data until the next IDLE grant.
REQ-020 disp_data SHALL be passed bit-exact; no sign conversion or saturation (the display driver handles negation).
REQ-021 disp_data and owner SHALL remain stable between grants.
REQ-022 A sole continuously-requesting requester SHALL be re-granted every HOLD_CYCLES+2 cycles (IDLE+LOAD+HOLD).
REQ-023 At most one ack bit SHALL be high in any cycle, and only when disp_sel is high.

Reset
REQ-024 On rst_n low, asynchronously: state=IDLE, disp_sel=0, ack=0, disp_data=0, owner=0, busy=0, hold counter=0, last_grant=3, so requester 0 has first priority.
REQ-025 Reset mid-LOAD or mid-HOLD SHALL abort without ack; arbitration SHALL restart from IDLE on the first edge after rst_n rises.

Structure
REQ-026 Shared package disp_pkg SHALL hold the state enum, N_REQ, the value width (11), and the hold-counter width (32).
REQ-027 Sub-module rr_arbiter SHALL implement the purely combinational round-robin pick (req, last_grant -> grant index, grant valid); disp_sched SHALL own all registers.

Verification (HOLD_CYCLES=8)
REQ-028 After reset, req=4'b0100 with slice2=11'h005: disp_sel and ack=4'b0100 for one cycle, disp_data=11'h005, owner=2, busy high for 9 cycles.
REQ-029 After reset, req=4'b1111 held: grants in order 0,1,2,3,0, spaced 10 cycles apart.
REQ-030 req0 and req2 held continuously: grants alternate 0,2,0,2; req1 and req3 never acked.
REQ-031 slice1=11'h7FB (-5): disp_data=11'h7FB exactly on grant.
REQ-032 rst_n pulsed low in HOLD cycle 4: outputs zero immediately, no ack; after release with req=4'b1010, first grant is requester 1.
REQ-033 req3 high for one cycle, dropped on capture edge: ack[3] still pulses with the captured data.
